// File: rtl/mux_n_pipe.sv
// N-input registered select mux with a valid/ready handshake and a 2-entry skid buffer.
// Define MUX_N_PIPE_ERR_CNT_EN to build the saturating out-of-range select counter on err_count.
module mux_n_pipe #(
  parameter int DATA_W = 16,
  parameter int N_IN   = 3,
  localparam int SEL_W = (N_IN > 2) ? $clog2(N_IN) : 1
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_sel_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             err_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic                main_err_q, main_err_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                skid_err_q, skid_err_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;

  logic [DATA_W-1:0]   sel_word;
  logic                sel_err;
  logic                in_xfer;
  logic                out_xfer;

  // Unmatched select codes fall back to input 0 and raise the error flag.
  always_comb begin
    sel_word = in_data[DATA_W-1:0];
    sel_err  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_word = in_data[k*DATA_W +: DATA_W];
        sel_err  = 1'b0;
      end
    end
  end

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_data_d = sel_word;
          main_err_d  = sel_err;
          state_d     = ONE;
        end
      end
      ONE: begin
        case ({in_xfer, out_xfer})
          2'b11: begin
            main_data_d = sel_word;
            main_err_d  = sel_err;
          end
          2'b10: begin
            skid_data_d = sel_word;
            skid_err_d  = sel_err;
            state_d     = FULL;
          end
          2'b01:   state_d = EMPTY;
          default: state_d = ONE;
        endcase
      end
      FULL: begin
        if (out_xfer) begin
          main_data_d = skid_data_q;
          main_err_d  = skid_err_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Handshake outputs come straight from flops; out_ready never reaches in_ready combinationally.
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = main_data_q;
  assign out_sel_err = main_err_q;

`ifdef MUX_N_PIPE_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_xfer && sel_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe: driver pushes expected words, a negedge monitor pops and compares.
module tb_mux_n_pipe;

  typedef struct packed {
    logic [15:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [47:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_sel_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  err_count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  localparam logic [47:0] VEC_ABC = {16'h3333, 16'h2222, 16'h1111};

  mux_n_pipe dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_sel_err(out_sel_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Drive one word and hold it until accepted; returns 1 time unit after the acceptance edge.
  task automatic send(input logic [47:0] d, input logic [1:0] s, input logic [15:0] ed, input logic ee);
    bit got = 0;
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_accept actual=not_accepted expected=accepted");
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{d: ed, e: ee});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: a transfer occurs at the next rising edge when valid & ready are seen here.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_err;
  always @(negedge clk) begin
    if (prev_stall && out_valid) begin
      chk("stall_hold_data", 32'(out_data), 32'(prev_data));
      chk("stall_hold_err", 32'(out_sel_err), 32'(prev_err));
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_err   = out_sel_err;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h expected=none", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_sel_err", 32'(out_sel_err), 32'(e.e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    #12 arst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel_err", 32'(out_sel_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;

    // Basic select, full throughput
    out_ready = 1'b1;
    send(VEC_ABC, 2'd0, 16'h1111, 1'b0);
    chk("basic_valid0", 32'(out_valid), 32'd1);
    chk("basic_data0", 32'(out_data), 32'h1111);
    send(VEC_ABC, 2'd1, 16'h2222, 1'b0);
    chk("basic_valid1", 32'(out_valid), 32'd1);
    chk("basic_ready1", 32'(in_ready), 32'd1);
    chk("basic_data1", 32'(out_data), 32'h2222);
    send(VEC_ABC, 2'd2, 16'h3333, 1'b0);
    chk("basic_valid2", 32'(out_valid), 32'd1);
    chk("basic_ready2", 32'(in_ready), 32'd1);
    chk("basic_data2", 32'(out_data), 32'h3333);

    // Out-of-range select
    chk("oor_cnt_before", 32'(err_count), 32'd0);
    send(VEC_ABC, 2'd3, 16'h1111, 1'b1);
    chk("oor_data", 32'(out_data), 32'h1111);
    chk("oor_err", 32'(out_sel_err), 32'd1);
`ifdef MUX_N_PIPE_ERR_CNT_EN
    chk("oor_cnt_after", 32'(err_count), 32'd1);
`else
    chk("oor_cnt_after", 32'(err_count), 32'd0);
`endif
    @(posedge clk);
    #1;

    // Backpressure
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    send({16'h3333, 16'hAAAA, 16'h1111}, 2'd1, 16'hAAAA, 1'b0);
    chk("bp_ready_after_w0", 32'(in_ready), 32'd1);
    send({16'h3333, 16'hBBBB, 16'h1111}, 2'd1, 16'hBBBB, 1'b0);
    chk("bp_ready_after_w1", 32'(in_ready), 32'd0);
    chk("bp_head_w0", 32'(out_data), 32'hAAAA);
    fork
      send({16'h3333, 16'hCCCC, 16'h1111}, 2'd1, 16'hCCCC, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ready_held", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", 32'(sb.size()), 32'd0);
    chk("bp_empty_valid", 32'(out_valid), 32'd0);

    // Mid-operation reset from FULL
    out_ready = 1'b0;
    send(VEC_ABC, 2'd0, 16'h1111, 1'b0);
    send(VEC_ABC, 2'd1, 16'h2222, 1'b0);
    chk("mr_full_ready", 32'(in_ready), 32'd0);
    #1 arst_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_err_count", 32'(err_count), 32'd0);
    sb.delete();
    #1 arst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(VEC_ABC, 2'd2, 16'h3333, 1'b0);
    chk("mr_latency_valid", 32'(out_valid), 32'd1);
    chk("mr_latency_data", 32'(out_data), 32'h3333);
    @(posedge clk);
    #1;

    // Counter saturation
    for (int i = 0; i < 300; i++) begin
      send(VEC_ABC, 2'd3, 16'h1111, 1'b1);
    end
`ifdef MUX_N_PIPE_ERR_CNT_EN
    chk("sat_count", 32'(err_count), 32'd255);
    send(VEC_ABC, 2'd3, 16'h1111, 1'b1);
    chk("sat_hold", 32'(err_count), 32'd255);
`else
    chk("sat_count", 32'(err_count), 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N-input, DATA_W-wide datapath multiplexer with a registered output stage and a valid/ready handshake on both sides.
- Generalises the fixed 3-input combinational select mux used for forwarding and ALU-operand selection in the pipeline.
- Adds backpressure through a 2-entry skid buffer, so in_ready is a registered signal and full throughput is sustained.
- Flags out-of-range selects.

Parameters:
- DATA_W, 16, width of each data input and of the output.
- N_IN, 3, number of data inputs; legal range 2..16.
- SEL_W, $clog2(N_IN), select width; localparam, minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- arst_n  input  1  asynchronous active-low reset.
- in_data  input  N_IN*DATA_W  packed inputs; input k occupies bits [k*DATA_W +: DATA_W].
- in_sel  input  SEL_W  index of the input to forward.
- in_valid  input  1  upstream has a word (in_data/in_sel) to transfer.
- in_ready  output  1  block accepts a word this cycle; registered.
- out_data  output  DATA_W  selected data; registered.
- out_sel_err  output  1  qualifies out_data; 1 = the select was >= N_IN.
- out_valid  output  1  out_data/out_sel_err hold a valid word.
- out_ready  input  1  downstream accepts the word.
- err_count  output  8  count of accepted out-of-range selects; see Optional Feature.

Behaviour:
- Reset (arst_n low, asynchronous assert, synchronous release): out_valid=0, out_data=0, out_sel_err=0, in_ready=1, skid buffer empty, err_count=0.
- Selection:
  - sel < N_IN: word = input[sel], err=0.
  - sel >= N_IN: word = input 0, err=1.
  - No X propagation for unused codes.
- Transfers:
  - Input transfer on in_valid & in_ready at the rising edge.
  - Output transfer on out_valid & out_ready at the rising edge.
  - Data, sel and err are sampled only on an input transfer.
- Latency: an accepted word appears on out_data with out_valid=1 on the first cycle after acceptance.
- Storage: main (output) register plus one skid register.
- States:
  - EMPTY: out_valid=0, skid empty.
  - ONE: out_valid=1, skid empty.
  - FULL: out_valid=1, skid occupied.
- Transitions:
  - EMPTY, input transfer -> ONE; word loaded into the main register.
  - ONE, input only -> FULL; word goes to the skid register and in_ready drops to 0 on the next cycle.
  - ONE, output only -> EMPTY.
  - ONE, input and output in the same cycle -> ONE; new word loaded into the main register, no bubble.
  - FULL, output transfer -> ONE; skid word moves to the main register, in_ready returns to 1 on the next cycle.
  - FULL, no input transfer is possible (in_ready=0).
- in_ready = ~skid_occupied, driven from a flop; no combinational path from out_ready to in_ready.
- Ordering is strictly FIFO; there are no drops and no duplicates.
- Stability: while out_valid=1 and out_ready=0, out_data and out_sel_err hold stable.
- in_valid while in_ready=0 is ignored; upstream must hold its word.
- Reset mid-operation: all stored words are discarded and the block returns to EMPTY immediately, without waiting for a clock edge.

Optional Feature:
- Macro: MUX_N_PIPE_ERR_CNT_EN.
- Defined:
  - err_count is an 8-bit saturating counter.
  - It increments by 1 on every input transfer whose in_sel >= N_IN.
  - It holds at 255 and is cleared only by reset.
  - It is updated on the same edge as the input transfer.
- Not defined: err_count is tied to 0 and no counter flops are synthesised.
- The port exists in both builds.

Test Plan:
- Reset, then idle: after reset release, in_ready=1, out_valid=0, out_data=0, out_sel_err=0.
- Basic select, DATA_W=16, N_IN=3:
  - Stimulus: in_data = {C:16'h3333, B:16'h2222, A:16'h1111}, out_ready held 1; send sel=0,1,2 on consecutive cycles.
  - Response: out_data = 1111, 2222, 3333 on cycles 1, 2, 3 after the first acceptance; no bubbles; in_ready stays 1.
- Out-of-range select:
  - Stimulus: sel=3 with A=16'h1111.
  - Response: out_data=16'h1111, out_sel_err=1.
  - With MUX_N_PIPE_ERR_CNT_EN: err_count goes 0->1 on the acceptance edge.
  - Without the macro: err_count stays 0.
- Backpressure:
  - Stimulus: out_ready=0; send words W0, W1, W2 back-to-back.
  - Response:
    - W0 and W1 are accepted; in_ready=0 from the cycle after W1 is accepted; W2 is held upstream.
    - Raise out_ready: W0, W1, W2 are delivered in order and none is lost.
- Counter saturation (macro defined): 300 accepted selects with sel=3 -> err_count = 255 and stays there.
- Mid-operation reset:
  - Stimulus: FULL state, pulse arst_n low for a half cycle between clock edges.
  - Response: out_valid=0 and in_ready=1 immediately; the next accepted word appears 1 cycle after acceptance.
